// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single signed add/subtract unit.
// One operation in flight at a time: accept in IDLE, compute in EXEC, hold the result in RESP.
module alu_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_ovf,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_lastGrant;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;

    logic             w_idle;
    logic             w_grant1;
    logic             w_accept;
    logic [WIDTH-1:0] w_bOperand;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    // Requester 1 wins when it is alone, or when both contend and requester 0 went last.
    assign w_idle     = (r_state == IDLE);
    assign w_grant1   = req1_valid && (!req0_valid || !r_lastGrant);
    assign req0_ready = w_idle && req0_valid && !w_grant1;
    assign req1_ready = w_idle && w_grant1;
    assign w_accept   = req0_ready || req1_ready;

    assign rsp_valid  = (r_state == RESP);
    assign busy       = !w_idle;

    // Subtraction as a + ~b + 1; overflow when the effective operands agree in sign but the sum does not.
    assign w_bOperand = r_sub ? ~r_b : r_b;
    assign w_sum      = r_a + w_bOperand + {{(WIDTH-1){1'b0}}, r_sub};
    assign w_ovf      = (r_a[WIDTH-1] == w_bOperand[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_lastGrant <= 1'b1;
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
            rsp_ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a         <= req1_ready ? req1_a   : req0_a;
                        r_b         <= req1_ready ? req1_b   : req0_b;
                        r_sub       <= req1_ready ? req1_sub : req0_sub;
                        rsp_id      <= req1_ready;
                        r_lastGrant <= req1_ready;
                        r_state     <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= w_sum;
                    rsp_ovf    <= w_ovf;
                    r_state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a negedge monitor models arbitration and arithmetic into a
// scoreboard, while the main sequence walks through arithmetic, contention, backpressure and reset.
module tb_alu_arbiter;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_sub;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_sub;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_ovf, busy;
    logic [W-1:0] rsp_result;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_ovf    (rsp_ovf),
        .busy       (busy)
    );

    typedef struct {
        logic         id;
        logic [W-1:0] res;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    int           grantLog[$];
    int           testsRun = 0;
    int           testsFailed = 0;
    int           cyc = 0;
    logic         mLast = 1'b1;
    bit           rspSeen = 1'b0;
    logic         lastId = 1'b0;
    logic [W-1:0] lastRes = '0;
    logic         lastOvf = 1'b0;
    logic         expG;
    logic         accId;
    exp_t         ent;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic v1, input logic rr);
        req0_valid = v0;
        req1_valid = v1;
        rsp_ready  = rr;
    endtask

    // Reference arithmetic done one bit wider; overflow is a disagreement of the top two bits.
    function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input int acc);
        logic [W:0] ext;
        exp_t       e;
        ext   = sub ? ({a[W-1], a} - {b[W-1], b}) : ({a[W-1], a} + {b[W-1], b});
        e.id  = id;
        e.res = ext[W-1:0];
        e.ovf = ext[W] ^ ext[W-1];
        e.acc = acc;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_ready || req1_ready) begin
                checkOutput("one_ready", {63'd0, req0_ready && req1_ready}, 64'd0);
                checkOutput("ready_needs_valid",
                            {63'd0, (req0_ready && !req0_valid) || (req1_ready && !req1_valid)}, 64'd0);
                expG = (req0_valid && req1_valid) ? !mLast : req1_valid;
                checkOutput("grant", {63'd0, req1_ready}, {63'd0, expG});
                accId = req1_ready;
                ent = accId ? model(1'b1, req1_a, req1_b, req1_sub, cyc)
                            : model(1'b0, req0_a, req0_b, req0_sub, cyc);
                sb.push_back(ent);
                grantLog.push_back(int'(accId));
                mLast = accId;
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_rsp", 64'd1, 64'd0);
                end else begin
                    checkOutput("rsp_id", {63'd0, rsp_id}, {63'd0, sb[0].id});
                    checkOutput("rsp_result", rsp_result, sb[0].res);
                    checkOutput("rsp_ovf", {63'd0, rsp_ovf}, {63'd0, sb[0].ovf});
                    if (!rspSeen) begin
                        checkOutput("latency", 64'(cyc - sb[0].acc), 64'd2);
                        rspSeen = 1'b1;
                    end
                    if (rsp_ready) begin
                        lastId  = rsp_id;
                        lastRes = rsp_result;
                        lastOvf = rsp_ovf;
                        void'(sb.pop_front());
                        rspSeen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic sendOp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        bit got = 1'b0;
        if (id) begin
            req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
        end
        if (!got) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        // Scrambled operands must not leak into the in-flight result.
        req0_a = {$urandom, $urandom};
        req0_b = {$urandom, $urandom};
        req1_a = {$urandom, $urandom};
        req1_b = {$urandom, $urandom};
    endtask

    task automatic waitDrain();
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk);
            done = (sb.size() == 0);
        end
        if (!done) checkOutput("drain_timeout", 64'd0, 64'd1);
        #1;
    endtask

    task automatic waitGrants(input int n);
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            done = (grantLog.size() >= n);
        end
        if (!done) checkOutput("grant_timeout", 64'(grantLog.size()), 64'(n));
        #1;
        applyStimulus(1'b0, 1'b0, 1'b1);
    endtask

    task automatic enterReset();
        rst_n = 1'b0;
        sb.delete();
        mLast   = 1'b1;
        rspSeen = 1'b0;
    endtask

    initial begin
        req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        enterReset();
        repeat (2) @(negedge clk);
        checkOutput("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("reset_rsp_id", {63'd0, rsp_id}, 64'd0);
        checkOutput("reset_rsp_result", rsp_result, 64'd0);
        checkOutput("reset_rsp_ovf", {63'd0, rsp_ovf}, 64'd0);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        sendOp(1'b0, -64'sd34359738368, 64'd20, 1'b0);
        waitDrain();
        checkOutput("sanity_result", lastRes, 64'hFFFF_FFF8_0000_0014);
        checkOutput("sanity_id", {63'd0, lastId}, 64'd0);
        checkOutput("sanity_ovf", {63'd0, lastOvf}, 64'd0);

        sendOp(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        waitDrain();
        checkOutput("addovf_result", lastRes, 64'h8000_0000_0000_0000);
        checkOutput("addovf_ovf", {63'd0, lastOvf}, 64'd1);
        checkOutput("addovf_id", {63'd0, lastId}, 64'd1);

        sendOp(1'b0, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
        waitDrain();
        checkOutput("subovf_result", lastRes, 64'h7FFF_FFFF_FFFF_FFFF);
        checkOutput("subovf_ovf", {63'd0, lastOvf}, 64'd1);

        sendOp(1'b0, 64'd5, 64'd7, 1'b1);
        waitDrain();
        checkOutput("subneg_result", lastRes, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("subneg_ovf", {63'd0, lastOvf}, 64'd0);

        // Contention straight out of reset: requester 0 must win first, then strict alternation.
        @(posedge clk);
        #1 enterReset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        grantLog.delete();
        req0_a = 64'd10; req0_b = 64'd3; req0_sub = 1'b0;
        req1_a = '1;     req1_b = 64'd2; req1_sub = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitGrants(4);
        waitDrain();
        checkOutput("cont_count", 64'(grantLog.size()), 64'd4);
        for (int i = 0; i < 4 && i < grantLog.size(); i++)
            checkOutput($sformatf("cont_grant%0d", i), 64'(grantLog[i]), 64'(i % 2));

        applyStimulus(1'b0, 1'b0, 1'b0);
        sendOp(1'b0, 64'd100, -64'sd3, 1'b1);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                seen = rsp_valid;
            end
            if (!seen) checkOutput("bp_rsp_timeout", 64'd0, 64'd1);
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            checkOutput("bp_result", rsp_result, 64'd103);
            checkOutput("bp_ovf", {63'd0, rsp_ovf}, 64'd0);
            checkOutput("bp_id", {63'd0, rsp_id}, 64'd0);
            checkOutput("bp_ready0", {63'd0, req0_ready}, 64'd0);
            checkOutput("bp_ready1", {63'd0, req1_ready}, 64'd0);
            checkOutput("bp_busy", {63'd0, busy}, 64'd1);
        end
        @(posedge clk);
        #1 applyStimulus(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("no_accept_on_rsp", {63'd0, req0_ready || req1_ready}, 64'd0);
        @(negedge clk);
        checkOutput("bp_idle", {63'd0, busy}, 64'd0);
        checkOutput("bp_next_grant1", {63'd0, req1_ready}, 64'd1);
        @(posedge clk);
        #1 applyStimulus(1'b0, 1'b0, 1'b1);
        waitDrain();

        // Reset while the operation sits in EXEC; it must vanish without a response.
        sendOp(1'b0, 64'd1, 64'd2, 1'b0);
        enterReset();
        #1;
        checkOutput("rst_exec_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("rst_exec_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("no_stale_rsp", {63'd0, rsp_valid}, 64'd0);
        end
        grantLog.delete();
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitGrants(2);
        waitDrain();
        checkOutput("post_rst_count", 64'(grantLog.size()), 64'd2);
        for (int i = 0; i < 2 && i < grantLog.size(); i++)
            checkOutput($sformatf("post_rst_grant%0d", i), 64'(grantLog[i]), 64'(i % 2));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
